// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter: round-robin shares one parity checker among NUM_REQ
// requesters and keeps a saturating mismatch counter per requester.
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid/req_ready            per-requester handshake (ready one-hot/0)
//   req_data_1/2, req_sel          packed operands, requester i at slice i
//   req_parity                     expected parity bit per requester
//   rsp_valid/rsp_ready            result handshake
//   rsp_id, rsp_err                owner of the result, 1 = mismatch
//   err_cnt, err_cnt_clr           packed counters, synchronous clear
//   busy                           high while not idle
module parity_check_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 3,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 8,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_2,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]    req_sel,
  input  logic [NUM_REQ-1:0]              req_parity,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic                            rsp_err,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    err_cnt,
  input  logic                            err_cnt_clr,
  output logic                            busy
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  logic [DATA_WIDTH-1:0] d2_q, d2_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  par_q, par_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;

  // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found &&
          req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    sel_d     = sel_q;
    par_d     = par_q;
    id_d      = id_q;
    rsp_err_d = rsp_err_q;
    rsp_id_d  = rsp_id_q;
    cnt_d     = cnt_q;
    req_ready = '0;

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_id] = 1'b1;
          d1_d  = req_data_1[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
          d2_d  = req_data_2[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
          sel_d = req_sel[int'(gnt_id)*SEL_WIDTH +: SEL_WIDTH];
          par_d = req_parity[gnt_id];
          id_d  = gnt_id;
          state_d = CHECK;
        end
      end
      CHECK: begin
        rsp_err_d = par_q ^ (^{d1_q, d2_q, sel_q});
        rsp_id_d  = id_q;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (rsp_err_q && (cnt_q[rsp_id_q] != '1)) begin
            cnt_d[rsp_id_q] = cnt_q[rsp_id_q] + CNT_WIDTH'(1);
          end
          if (rsp_id_q == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = rsp_id_q + ID_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides a coincident increment.
    if (err_cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      sel_q     <= '0;
      par_q     <= 1'b0;
      id_q      <= '0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      sel_q     <= sel_d;
      par_q     <= par_d;
      id_q      <= id_d;
      rsp_err_q <= rsp_err_d;
      rsp_id_q  <= rsp_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = cnt_q;

endmodule
